// File: rtl/ysyx_23060077_riscv_bus_arbiter_n_pkg.sv
// Shared types for the N-master round-robin bus arbiter: FSM state encoding,
// default bus widths and the round-robin pointer width helper.
package ysyx_23060077_riscv_bus_arbiter_n_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StRsp  = 2'd2,
    StDone = 2'd3
  } arb_state_e;

  localparam int unsigned DefaultAddrW = 32;
  localparam int unsigned DefaultDataW = 32;

  // A single master still needs a 1-bit pointer so the ports stay legal.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_23060077_rr_picker.sv
// Combinational round-robin picker: selects the first requester at an index
// >= rr_ptr, wrapping to the lowest index when none is found above the pointer.
module ysyx_23060077_rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_req
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    any_req   = |req;
    // First pass covers [rr_ptr, NUM_REQ), second pass the wrapped-around part.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i >= 32'(rr_ptr))) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/ysyx_23060077_riscv_bus_arbiter_n.sv
// N-master round-robin arbiter serialising requests onto one downstream port.
// Define ARB_TIMEOUT_EN to abort a stalled transaction after TIMEOUT_CYCLES.
module ysyx_23060077_riscv_bus_arbiter_n
  import ysyx_23060077_riscv_bus_arbiter_n_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_W         = DefaultAddrW,
  parameter int unsigned DATA_W         = DefaultDataW,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            s_valid,
  input  logic [NUM_MASTERS-1:0]            s_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     s_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]     s_wdata,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] s_wstrb,
  output logic [NUM_MASTERS-1:0]            s_ready,
  output logic [DATA_W-1:0]                 s_rdata,
  output logic                              s_err,
  output logic                              m_req_valid,
  input  logic                              m_req_ready,
  output logic                              m_we,
  output logic [ADDR_W-1:0]                 m_addr,
  output logic [DATA_W-1:0]                 m_wdata,
  output logic [DATA_W/8-1:0]               m_wstrb,
  input  logic                              m_rsp_valid,
  input  logic [DATA_W-1:0]                 m_rsp_rdata,
  input  logic                              m_rsp_err
);

  localparam int unsigned PtrW  = ptr_width(NUM_MASTERS);
  localparam int unsigned StrbW = DATA_W / 8;

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  arb_state_e        state_q, state_d;
  logic [PtrW-1:0]   grant_q, grant_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [StrbW-1:0]  m_wstrb_q, m_wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [NUM_MASTERS-1:0] pick_oh;
  logic [PtrW-1:0]        pick_idx;
  logic                   any_req;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [StrbW-1:0]  sel_wstrb;

  ysyx_23060077_rr_picker #(
    .NUM_REQ (NUM_MASTERS),
    .PTR_W   (PtrW)
  ) u_picker (
    .req       (s_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_oh),
    .grant_idx (pick_idx),
    .any_req   (any_req)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (pick_oh[i]) begin
        sel_we    = s_we[i];
        sel_addr  = s_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = s_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = s_wstrb[i*StrbW +: StrbW];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy;
  logic            timeout_hit;

  assign busy        = (state_q == StReq) || (state_q == StRsp);
  // Fires in the cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout_hit = busy && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d   = pick_idx;
          m_we_d    = sel_we;
          m_addr_d  = sel_addr;
          m_wdata_d = sel_wdata;
          m_wstrb_d = sel_wstrb;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (m_req_ready) begin
          state_d = StRsp;
        end
`ifdef ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end
`endif
      end
      StRsp: begin
        if (m_rsp_valid) begin
          rdata_d = m_rsp_rdata;
          err_d   = m_rsp_err;
          state_d = StDone;
        end
`ifdef ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end
`endif
      end
      StDone: begin
        rr_ptr_d = (grant_q == PtrW'(NUM_MASTERS - 1)) ? '0 : grant_q + PtrW'(1);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    m_req_valid = (state_q == StReq);
    s_ready     = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if ((state_q == StDone) && (grant_q == PtrW'(i))) begin
        s_ready[i] = 1'b1;
      end
    end
  end

  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign s_rdata = rdata_q;
  assign s_err   = err_q;

endmodule
